// File: rtl/j4_slot_sched.sv
// rtl/j4_slot_sched.sv - j4 thread-slot scheduler: taskexec vectors, slot lifecycle, kill pulses
// Optional watchdog build: define J4_SLOT_WDOG_EN (counter width set by WDOG_W).
module j4_slot_sched #(
    parameter int WDOG_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    input  logic [1:0]  io_slot,
    output logic [15:0] rd_data,
    output logic [3:0]  kill_slot_rq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2
    } slot_state_t;

    // Stage-1 copies of the core IO bus
    logic        rd_s1;
    logic        wr_s1;
    logic [15:0] addr_s1;
    logic [15:0] dout_s1;
    logic [1:0]  slot_s1;

    // Per-slot lifecycle and entry vectors (slot 0 has neither)
    slot_state_t state_q  [1:3];
    slot_state_t state_n  [1:3];
    logic [15:0] taskexec_q [1:3];
    logic [15:0] taskexec_n [1:3];

    logic [3:1]  wr_te;
    logic        rd_te;
    logic        rd_stat;
    logic        rd_slot;
    logic        wr_kill;
    logic [3:0]  self_bit;
    logic [3:1]  sw_kill;
    logic [3:1]  wdog_hit;
    logic [3:1]  kill_mask;
    logic [3:1]  timeout_flags;
    logic [15:0] status;
    logic [3:0]  kill_q;

    // Register the bus; address is zeroed when no strobe so idle cycles decode nothing
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_s1   <= 1'b0;
            wr_s1   <= 1'b0;
            addr_s1 <= '0;
            dout_s1 <= '0;
            slot_s1 <= '0;
        end else begin
            rd_s1   <= io_rd;
            wr_s1   <= io_wr;
            addr_s1 <= (io_rd || io_wr) ? mem_addr : 16'd0;
            dout_s1 <= dout;
            slot_s1 <= io_slot;
        end
    end

    // One-hot address decode qualified by the matching strobe
    always_comb begin
        wr_te    = wr_s1 ? addr_s1[10:8] : 3'b000;
        rd_te    = rd_s1 && addr_s1[14];
        rd_stat  = rd_s1 && addr_s1[11];
        rd_slot  = rd_s1 && addr_s1[15];
        wr_kill  = wr_s1 && addr_s1[14];
        self_bit = 4'b0001 << slot_s1;
        sw_kill  = 3'b000;
        if (wr_kill) begin
            // Supervisor kills by mask; any other slot can only yield itself
            sw_kill = (slot_s1 == 2'd0) ? dout_s1[3:1] : self_bit[3:1];
        end
        kill_mask = sw_kill | wdog_hit;
    end

    // Slot next state: kill applies first, a taskexec write then overrides it
    always_comb begin
        for (int n = 1; n <= 3; n++) begin
            state_n[n]    = state_q[n];
            taskexec_n[n] = taskexec_q[n];
            if (kill_mask[n]) begin
                state_n[n]    = IDLE;
                taskexec_n[n] = 16'd0;
            end
            if (wr_te[n]) begin
                taskexec_n[n] = dout_s1;
                state_n[n]    = (dout_s1 != 16'd0) ? ARMED : IDLE;
            end else if (!kill_mask[n] && rd_te && (slot_s1 == n[1:0]) && (state_q[n] == ARMED)) begin
                state_n[n] = RUNNING;
            end
        end
    end

    // Slot state, taskexec and the registered kill pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 1; n <= 3; n++) begin
                state_q[n]    <= IDLE;
                taskexec_q[n] <= 16'd0;
            end
            kill_q <= 4'd0;
        end else begin
            for (int n = 1; n <= 3; n++) begin
                state_q[n]    <= state_n[n];
                taskexec_q[n] <= taskexec_n[n];
            end
            kill_q <= {kill_mask, 1'b0};
        end
    end

    assign kill_slot_rq = kill_q;

`ifdef J4_SLOT_WDOG_EN
    logic [WDOG_W-1:0] reload_q;
    logic [WDOG_W-1:0] cnt_q [1:3];
    logic [3:1]        io_from;
    logic [3:1]        timeout_q;
    logic              unused_bits;

    assign unused_bits = ^{addr_s1[13:12], addr_s1[6:0]};

    // A running slot times out when its counter runs down without any IO of its own
    always_comb begin
        for (int n = 1; n <= 3; n++) begin
            io_from[n]  = (rd_s1 || wr_s1) && (slot_s1 == n[1:0]);
            wdog_hit[n] = (reload_q != '0) && (state_q[n] == RUNNING) &&
                          !io_from[n] && (cnt_q[n] <= WDOG_W'(1));
        end
    end

    // Reload value, per-slot counters and sticky timeout flags
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q  <= '1;
            timeout_q <= 3'b000;
            for (int n = 1; n <= 3; n++) cnt_q[n] <= '0;
        end else begin
            if (wr_s1 && addr_s1[7] && (slot_s1 == 2'd0))
                reload_q <= WDOG_W'(dout_s1);
            timeout_q <= ((rd_stat && (slot_s1 == 2'd0)) ? 3'b000 : timeout_q) | wdog_hit;
            for (int n = 1; n <= 3; n++) begin
                if ((state_n[n] == RUNNING) && ((state_q[n] != RUNNING) || io_from[n]))
                    cnt_q[n] <= reload_q;
                else if ((state_q[n] == RUNNING) && (cnt_q[n] != '0))
                    cnt_q[n] <= cnt_q[n] - 1'b1;
            end
        end
    end

    assign timeout_flags = timeout_q;
`else
    localparam int unused_wdog_w = WDOG_W;
    logic          unused_bits;

    assign unused_bits   = ^{addr_s1[13:12], addr_s1[7:0]};
    assign wdog_hit      = 3'b000;
    assign timeout_flags = 3'b000;
`endif

    // Read mux: OR of every selected source, zero when nothing is selected
    always_comb begin
        status  = {7'd0, timeout_flags, state_q[3], state_q[2], state_q[1]};
        rd_data = 16'd0;
        if (rd_te) begin
            case (slot_s1)
                2'd1:    rd_data = taskexec_q[1];
                2'd2:    rd_data = taskexec_q[2];
                2'd3:    rd_data = taskexec_q[3];
                default: rd_data = 16'd0;
            endcase
        end
        if (rd_stat)
            rd_data = rd_data | status;
        if (rd_slot)
            rd_data = rd_data | {14'd0, slot_s1};
    end

endmodule

// File: tb/tb_j4_slot_sched.sv
// tb/tb_j4_slot_sched.sv - directed and randomized check of j4_slot_sched against a slot model
module tb_j4_slot_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] mem_addr = 16'd0;
    logic [15:0] dout = 16'd0;
    logic [1:0]  io_slot = 2'd0;
    logic [15:0] rd_data;
    logic [3:0]  kill_slot_rq;

    int tests = 0;
    int fails = 0;

    // Model: per-slot entry vector and lifecycle (0 idle, 1 armed, 2 running)
    int m_te [1:3];
    int m_st [1:3];

    j4_slot_sched #(.WDOG_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .io_rd(io_rd),
        .io_wr(io_wr),
        .mem_addr(mem_addr),
        .dout(dout),
        .io_slot(io_slot),
        .rd_data(rd_data),
        .kill_slot_rq(kill_slot_rq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 1; n <= 3; n++) begin
            m_te[n] = 0;
            m_st[n] = 0;
        end
    endtask

    function automatic logic [15:0] model_read(input logic rd, input logic [15:0] addr, input int slot);
        logic [15:0] r;
        r = 16'd0;
        if (rd && addr[14] && slot != 0) r |= 16'(m_te[slot]);
        if (rd && addr[11]) r |= 16'(m_st[1] + 4 * m_st[2] + 16 * m_st[3]);
        if (rd && addr[15]) r |= 16'(slot);
        return r;
    endfunction

    task automatic model_apply(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] data, input int slot, output logic [3:0] kill);
        logic [3:0] km;
        km = 4'd0;
        if (wr && addr[14]) begin
            if (slot == 0) km = {data[3:1], 1'b0};
            else           km = 4'(1 << slot);
        end
        for (int n = 1; n <= 3; n++) begin
            if (km[n]) begin
                m_st[n] = 0;
                m_te[n] = 0;
            end
            if (wr && addr[7 + n]) begin
                m_te[n] = int'(data);
                m_st[n] = (data != 0) ? 1 : 0;
            end else if (rd && addr[14] && slot == n && m_st[n] == 1) begin
                m_st[n] = 2;
            end
        end
        kill = km;
    endtask

    // One bus operation: drive for one cycle, check read data, kill pulse and its end
    task automatic op(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data,
                      input logic [1:0] slot, output logic [15:0] rdo, output logic [3:0] ko);
        logic [15:0] exp_rd;
        logic [3:0]  exp_k;
        @(negedge clk);
        io_rd = rd; io_wr = wr; mem_addr = addr; dout = data; io_slot = slot;
        exp_rd = model_read(rd, addr, int'(slot));
        @(negedge clk);
        rdo = rd_data;
        chk("rd_data", rdo, exp_rd);
        io_rd = 1'b0; io_wr = 1'b0; mem_addr = 16'd0; dout = 16'd0;
        model_apply(rd, wr, addr, data, int'(slot), exp_k);
        @(negedge clk);
        ko = kill_slot_rq;
        chk("kill_pulse", {12'd0, ko}, {12'd0, exp_k});
        @(negedge clk);
        chk("kill_one_cycle", {12'd0, kill_slot_rq}, 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    logic [15:0] r;
    logic [3:0]  k;

    initial begin
        model_reset();
        do_reset();
        chk("reset_rd_data", rd_data, 16'd0);
        chk("reset_kill", {12'd0, kill_slot_rq}, 16'd0);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("reset_status", r, 16'h0000);

        // Arm slot 1, start it, observe status
        op(1'b0, 1'b1, 16'h0100, 16'h0100, 2'd0, r, k);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("status_armed", r, 16'h0001);
        op(1'b1, 1'b0, 16'h4000, 16'd0, 2'd1, r, k);
        chk("slot1_taskexec", r, 16'h0100);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("status_running", r, 16'h0002);

        // All slots running, supervisor kills with mask 0xF
        op(1'b0, 1'b1, 16'h0600, 16'h1234, 2'd0, r, k);
        op(1'b1, 1'b0, 16'h4000, 16'd0, 2'd2, r, k);
        op(1'b1, 1'b0, 16'h4000, 16'd0, 2'd3, r, k);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("status_all_running", r, 16'h002A);
        op(1'b0, 1'b1, 16'h4000, 16'h000F, 2'd0, r, k);
        chk("kill_all", {12'd0, k}, 16'h000E);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("status_after_kill", r, 16'h0000);
        for (int s = 1; s <= 3; s++) begin
            op(1'b1, 1'b0, 16'h4000, 16'd0, 2'(s), r, k);
            chk("taskexec_cleared", r, 16'h0000);
        end

        // Self-yield from slot 2
        op(1'b0, 1'b1, 16'h0700, 16'h00A5, 2'd0, r, k);
        op(1'b0, 1'b1, 16'h4000, 16'hBEEF, 2'd2, r, k);
        chk("self_yield", {12'd0, k}, 16'h0004);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("status_after_yield", r, 16'h0011);

        // Kill and re-arm in the same write
        op(1'b0, 1'b1, 16'h4100, 16'h0002, 2'd0, r, k);
        chk("kill_then_write", {12'd0, k}, 16'h0002);
        op(1'b1, 1'b0, 16'h0800, 16'd0, 2'd0, r, k);
        chk("slot1_rearmed", r, 16'h0011);
        op(1'b1, 1'b0, 16'h4000, 16'd0, 2'd1, r, k);
        chk("slot1_new_value", r, 16'h0002);

        // Slot id read, then no-strobe read
        op(1'b1, 1'b0, 16'h8000, 16'd0, 2'd3, r, k);
        chk("slot_id", r, 16'h0003);
        @(negedge clk);
        mem_addr = 16'h8000; io_slot = 2'd3;
        @(negedge clk);
        chk("no_strobe_read", rd_data, 16'h0000);
        mem_addr = 16'd0;

        // Reset while a kill is in flight
        @(negedge clk);
        io_wr = 1'b1; mem_addr = 16'h4000; dout = 16'h000E; io_slot = 2'd0;
        @(negedge clk);
        io_wr = 1'b0; mem_addr = 16'd0; dout = 16'd0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_aborts_kill", {12'd0, kill_slot_rq}, 16'h0000);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("kill_stays_low", {12'd0, kill_slot_rq}, 16'h0000);

        // Randomized operations against the model
        for (int i = 0; i < 200; i++) begin
            logic        rr, ww;
            logic [15:0] a, d;
            int          kind;
            kind = $urandom_range(0, 2);
            rr = (kind != 1);
            ww = (kind != 0);
            a = 16'd0;
            if ($urandom_range(0, 2) == 0) a[8]  = 1'b1;
            if ($urandom_range(0, 2) == 0) a[9]  = 1'b1;
            if ($urandom_range(0, 2) == 0) a[10] = 1'b1;
            if ($urandom_range(0, 2) == 0) a[11] = 1'b1;
            if ($urandom_range(0, 1) == 0) a[14] = 1'b1;
            if ($urandom_range(0, 3) == 0) a[15] = 1'b1;
            d = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            op(rr, ww, a, d, 2'($urandom_range(0, 3)), r, k);
        end

`ifdef J4_SLOT_WDOG_EN
        // Watchdog: reload 5, slot 1 runs with no IO
        do_reset();
        op(1'b0, 1'b1, 16'h0080, 16'd5, 2'd0, r, k);
        op(1'b0, 1'b1, 16'h0100, 16'h0042, 2'd0, r, k);
        op(1'b1, 1'b0, 16'h4000, 16'd0, 2'd1, r, k);
        begin
            int seen;
            seen = 0;
            for (int c = 2; c <= 20 && seen == 0; c++) begin
                @(negedge clk);
                if (kill_slot_rq[1]) seen = c;
            end
            chk("wdog_kill_cycle", 16'(seen), 16'd5);
        end
        model_reset();
        @(negedge clk);
        io_rd = 1'b1; mem_addr = 16'h0800; io_slot = 2'd1;
        @(negedge clk);
        chk("wdog_flag_set", rd_data, 16'h0040);
        io_slot = 2'd0;
        @(negedge clk);
        chk("wdog_flag_slot0_read", rd_data, 16'h0040);
        io_rd = 1'b0; mem_addr = 16'd0;
        @(negedge clk);
        io_rd = 1'b1; mem_addr = 16'h0800; io_slot = 2'd0;
        @(negedge clk);
        chk("wdog_flag_cleared", rd_data, 16'h0000);
        io_rd = 1'b0; mem_addr = 16'd0;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/j4_slot_sched.md
# j4_slot_sched

Memory-mapped thread-slot scheduler for the j4 4-way barrel core. It sits on the core's IO bus beside the UART decode and owns the per-slot task entry vectors (taskexec) for slots 1-3. It tracks each slot's lifecycle and drives the core's `kill_slot_rq` input. Slot 0 is the supervisor: it always boots from 0 and cannot be killed.

## Interface
Parameters:
- `WDOG_W`, 16, watchdog counter width; only used with `J4_SLOT_WDOG_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `io_rd`  in  1  core IO read strobe (undelayed).
- `io_wr`  in  1  core IO write strobe (undelayed).
- `mem_addr`  in  16  IO address; one-hot bit decode.
- `dout`  in  16  core write data.
- `io_slot`  in  2  slot issuing the current IO op.
- `rd_data`  out  16  read data; ORed into core `io_din`; 0 when unselected.
- `kill_slot_rq`  out  4  one-cycle kill pulse per slot; bit 0 is always 0.

## Operation
- Stage 1 registers inputs: `io_rd_`, `io_wr_`, `dout_`, `slot_`, and `addr_`. `addr_` is forced to 0 when neither strobe is high.
- Decode uses `addr_` bits, active only with the corresponding strobe.
  - Write bits 8/9/10: taskexec[1/2/3] <= `dout_`. Slot state becomes ARMED if `dout_`≠0, else IDLE.
  - Write bit 14 from slot 0: kill mask = `dout_[3:1]`.
  - Write bit 14 from slot n≠0: self-yield, kill mask = bit n.
  - Read bit 14: returns taskexec[`slot_`]. Slot 0 reads 0. An ARMED slot reading here moves to RUNNING.
  - Read bit 11: status. [1:0],[3:2],[5:4] = state of slots 1,2,3. [8:6] = timeout flags. Other bits 0.
  - Read bit 15: `{14'd0, slot_}`.
  - Multiple read bits set: `rd_data` is the OR of the selected sources.
- Per-slot FSM (slots 1-3), encoding IDLE=0, ARMED=1, RUNNING=2:
  - IDLE -> ARMED on a nonzero taskexec write.
  - ARMED -> RUNNING on own taskexec read.
  - Any state -> IDLE on kill. A kill clears that slot's taskexec and emits its kill pulse.
- Priority within one cycle: kill first, then taskexec write. A write with bits 14 and 8 both set pulses kill[1] and leaves slot 1 ARMED with the new value.
- Kill of an IDLE slot still pulses. Slot 0 is never killed; mask bit 0 is ignored.

## Timing
- Reset values: `rd_data`=0 (since `addr_`=0), `kill_slot_rq`=0, all taskexec=0, all states IDLE, timeout flags 0, stage-1 regs 0.
- Read latency: `io_rd` sampled at edge N; `rd_data` is valid during cycle N+1 (combinational from stage-1 regs). This matches the core's one-instruction `io_din` delay.
- Write latency: `io_wr` at edge N; registers update at edge N+1; `kill_slot_rq` is high for exactly cycle N+1..N+2 (registered, one cycle).
- A state change caused by a read takes effect at edge N+1.
- Reset asserted mid-operation aborts any pending kill pulse; outputs are 0 the cycle after reset is sampled.

## Configuration
- `J4_SLOT_WDOG_EN` defined:
  - Write bit 7 from slot 0 loads a `WDOG_W`-bit reload value. Reload reset value is all ones; writes from slots 1-3 are ignored.
  - Each RUNNING slot's counter decrements every clock. It reloads on entry to RUNNING and on any IO op from that slot.
  - Reaching 0 issues a kill for that slot and sets its sticky timeout flag.
  - A slot-0 read of status clears all timeout flags; a flag set in the same cycle wins.
  - A reload value of 0 disables the watchdog.
- Undefined: no counters exist, write bit 7 is ignored, and status [8:6] reads 0.

## Test plan
- Reset, then slot 0 writes 0x0100 @0x0100 → status reads 0x0001; slot 1 reads @0x4000 → 0x0100; status → 0x0002.
- Slot 0 writes 0x000F @0x4000 with all slots RUNNING → `kill_slot_rq`=4'b1110 for one cycle; status → 0; all taskexec read 0.
- Slot 2 writes anything @0x4000 → `kill_slot_rq`=4'b0100; slot 2 IDLE; slots 1/3 unchanged.
- Single write @0x4100 data 0x0002 from slot 0 → kill[1] pulses; slot 1 ends ARMED, taskexec[1]=0x0002.
- Slot 3 reads @0x8000 → 0x0003 the next cycle; reads with no strobe → `rd_data`=0.
- (`J4_SLOT_WDOG_EN`) Reload=5, slot 1 RUNNING with no IO → kill[1] pulses 5 cycles after RUNNING entry; status bit 6=1; slot-0 status read clears it.
